// File: rtl/pakrv_pkg.sv
// Shared definitions for the PakRV RV32I single-cycle core: opcodes,
// funct fields and the control enums used by decode, ALU and writeback.
package pakrv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_t;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} wb_sel_t;

  // alt selects SUB/SRA; callers only raise it where that encoding is legal
  function automatic alu_op_t alu_op_decode(input logic [2:0] funct3, input logic alt);
    alu_op_t op;
    case (funct3)
      F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/pakrv_alu.sv
// Integer ALU for the PakRV core; shifts use the low five bits of b.
module pakrv_alu
  import pakrv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  alu_op_t               op,
  output logic [DATA_WIDTH-1:0] result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, a < b};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/pakrv_ram.sv
// 1024-word memory with combinational read and clocked write; not reset.
// Used for both instruction memory (write tied off, preload only) and data memory.
module pakrv_ram #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [9:0]            addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] data_memory [0:1023];

  assign rdata = data_memory[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      data_memory[addr] <= wdata;
    end
  end

endmodule

// File: rtl/pakrv_rf.sv
// 32-entry register file: two combinational read ports, one clocked write port.
// x0 is hard-wired to zero on read and never written.
module pakrv_rf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [4:0]            rs1_addr,
  input  logic [4:0]            rs2_addr,
  input  logic [4:0]            rd_addr,
  input  logic                  rd_we,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data
);

  logic [DATA_WIDTH-1:0] regs [0:31];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (rd_we && (rd_addr != 5'd0)) begin
      regs[rd_addr] <= rd_data;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];

endmodule

// File: rtl/pakrv_core.sv
// PakRV single-cycle RV32I core: fetch, decode, execute, memory and writeback
// all retire on one rising edge of clk. Unsupported encodings retire as NOPs.
module pakrv_core
  import pakrv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input logic clk,
  input logic arst_n
);

  logic [DATA_WIDTH-1:0] pc, pc_next, pc_plus4, branch_target;
  logic [DATA_WIDTH-1:0] instr, imm;
  logic [DATA_WIDTH-1:0] rs1_data, rs2_data, rd_data;
  logic [DATA_WIDTH-1:0] alu_a, alu_b, alu_result, dmem_rdata;

  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;

  logic     rf_we, store_en, dmem_we, alu_a_pc, alu_b_imm;
  logic     is_branch, is_jal, is_jalr, br_taken;
  alu_op_t  alu_op;
  imm_sel_t imm_sel;
  wb_sel_t  wb_sel;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  pakrv_ram #(.DATA_WIDTH(DATA_WIDTH)) i_mem (
    .clk   (clk),
    .we    (1'b0),
    .addr  (pc[11:2]),
    .wdata ('0),
    .rdata (instr)
  );

  always_comb begin
    rf_we     = 1'b0;
    store_en  = 1'b0;
    alu_op    = ALU_ADD;
    alu_a_pc  = 1'b0;
    alu_b_imm = 1'b1;
    imm_sel   = IMM_I;
    wb_sel    = WB_ALU;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    case (opcode)
      OPC_OP: begin
        if ((funct7 == F7_BASE) ||
            ((funct7 == F7_ALT) && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA)))) begin
          rf_we     = 1'b1;
          alu_b_imm = 1'b0;
          alu_op    = alu_op_decode(funct3, funct7[5]);
        end
      end
      OPC_OP_IMM: begin
        // shift-immediates carry funct7 in imm[11:5]; other encodings there are illegal
        if (!((funct3 == F3_SLL) && (funct7 != F7_BASE)) &&
            !((funct3 == F3_SRL_SRA) && (funct7 != F7_BASE) && (funct7 != F7_ALT))) begin
          rf_we  = 1'b1;
          alu_op = alu_op_decode(funct3, (funct3 == F3_SRL_SRA) && funct7[5]);
        end
      end
      OPC_LOAD: begin
        if (funct3 == F3_LW) begin
          rf_we  = 1'b1;
          wb_sel = WB_MEM;
        end
      end
      OPC_STORE: begin
        if (funct3 == F3_SW) begin
          store_en = 1'b1;
          imm_sel  = IMM_S;
        end
      end
      OPC_BRANCH: begin
        is_branch = 1'b1;
        imm_sel   = IMM_B;
      end
      OPC_JAL: begin
        is_jal  = 1'b1;
        rf_we   = 1'b1;
        wb_sel  = WB_PC4;
        imm_sel = IMM_J;
      end
      OPC_JALR: begin
        if (funct3 == F3_JALR) begin
          is_jalr = 1'b1;
          rf_we   = 1'b1;
          wb_sel  = WB_PC4;
        end
      end
      OPC_LUI: begin
        rf_we   = 1'b1;
        wb_sel  = WB_IMM;
        imm_sel = IMM_U;
      end
      OPC_AUIPC: begin
        rf_we    = 1'b1;
        alu_a_pc = 1'b1;
        imm_sel  = IMM_U;
      end
      default: ;
    endcase
  end

  always_comb begin
    imm = '0;
    case (imm_sel)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  pakrv_rf #(.DATA_WIDTH(DATA_WIDTH)) i_rf (
    .clk      (clk),
    .arst_n   (arst_n),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rd_addr  (rd),
    .rd_we    (rf_we),
    .rd_data  (rd_data),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

  assign alu_a = alu_a_pc ? pc : rs1_data;
  assign alu_b = alu_b_imm ? imm : rs2_data;

  pakrv_alu #(.DATA_WIDTH(DATA_WIDTH)) i_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result)
  );

  always_comb begin
    br_taken = 1'b0;
    if (is_branch) begin
      case (funct3)
        F3_BEQ:  br_taken = (rs1_data == rs2_data);
        F3_BNE:  br_taken = (rs1_data != rs2_data);
        F3_BLT:  br_taken = ($signed(rs1_data) < $signed(rs2_data));
        F3_BGE:  br_taken = ($signed(rs1_data) >= $signed(rs2_data));
        F3_BLTU: br_taken = (rs1_data < rs2_data);
        F3_BGEU: br_taken = (rs1_data >= rs2_data);
        default: br_taken = 1'b0;
      endcase
    end
  end

  // a store decoded while reset is held must not land in memory
  assign dmem_we = store_en & arst_n;

  pakrv_ram #(.DATA_WIDTH(DATA_WIDTH)) i_dmem (
    .clk   (clk),
    .we    (dmem_we),
    .addr  (alu_result[11:2]),
    .wdata (rs2_data),
    .rdata (dmem_rdata)
  );

  assign pc_plus4      = pc + DATA_WIDTH'(4);
  assign branch_target = pc + imm;

  always_comb begin
    case (wb_sel)
      WB_MEM:  rd_data = dmem_rdata;
      WB_PC4:  rd_data = pc_plus4;
      WB_IMM:  rd_data = imm;
      default: rd_data = alu_result;
    endcase
  end

  always_comb begin
    if (is_jal || br_taken) begin
      pc_next = branch_target;
    end else if (is_jalr) begin
      pc_next = {alu_result[DATA_WIDTH-1:1], 1'b0};
    end else begin
      pc_next = pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pc <= '0;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: tb/tb_pakrv_core.sv
// Directed bench for pakrv_core: preloads small programs through hierarchical
// writes and checks registers, PC and data memory against hand-computed values.
module tb_pakrv_core;

  localparam logic [6:0] T_OP     = 7'b0110011;
  localparam logic [6:0] T_OP_IMM = 7'b0010011;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_JALR   = 7'b1100111;
  localparam logic [6:0] T_LUI    = 7'b0110111;
  localparam logic [6:0] T_AUIPC  = 7'b0010111;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic clk;
  logic arst_n;
  int   checks;
  int   errors;

  pakrv_core #(.DATA_WIDTH(32)) dut (
    .clk    (clk),
    .arst_n (arst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, T_OP};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 1024; i++) dut.i_mem.data_memory[i] = NOP;
  endtask

  task automatic put(input int addr, input logic [31:0] word);
    dut.i_mem.data_memory[addr/4] = word;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    arst_n = 1'b1;
    #1 arst_n = 1'b0;

    // Program A: arithmetic, compares, x0, memory, LUI/AUIPC, NOP encodings
    clear_imem();
    put(  0, enc_i(T_OP_IMM, 5'd1, 3'b000, 5'd0, 12'd5));
    put(  4, enc_i(T_OP_IMM, 5'd2, 3'b000, 5'd0, 12'hFFD));
    put(  8, enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3));
    put( 12, enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4));
    put( 16, enc_i(T_OP_IMM, 5'd5, 3'b101, 5'd2, 12'h401));
    put( 20, enc_i(T_OP_IMM, 5'd0, 3'b000, 5'd0, 12'd7));
    put( 24, enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd6));
    put( 28, enc_r(7'h00, 5'd1, 5'd2, 3'b011, 5'd7));
    put( 32, enc_i(T_OP_IMM, 5'd8, 3'b000, 5'd0, 12'h100));
    put( 36, enc_s(12'd4, 5'd1, 5'd8, 3'b010));
    put( 40, enc_i(T_LOAD, 5'd9, 3'b010, 5'd8, 12'd4));
    put( 44, enc_r(7'h00, 5'd9, 5'd9, 3'b000, 5'd12));
    put( 48, enc_u(20'h12345, 5'd10, T_LUI));
    put( 52, enc_u(20'h00001, 5'd11, T_AUIPC));
    put( 56, enc_s(12'd8, 5'd2, 5'd8, 3'b010));
    put( 60, enc_i(T_LOAD, 5'd13, 3'b010, 5'd8, 12'd8));
    put( 64, enc_i(T_OP_IMM, 5'd14, 3'b100, 5'd1, 12'h0FF));
    put( 68, enc_r(7'h00, 5'd1, 5'd2, 3'b101, 5'd15));
    put( 72, enc_i(T_OP_IMM, 5'd16, 3'b111, 5'd2, 12'h0F0));
    put( 76, enc_i(T_OP_IMM, 5'd17, 3'b110, 5'd1, 12'hFF0));
    put( 80, enc_r(7'h00, 5'd1, 5'd1, 3'b001, 5'd18));
    put( 84, enc_i(T_OP_IMM, 5'd19, 3'b010, 5'd2, 12'hFFE));
    put( 88, enc_i(T_OP_IMM, 5'd20, 3'b011, 5'd1, 12'hFFF));
    put( 92, enc_i(T_OP_IMM, 5'd21, 3'b001, 5'd1, 12'h01C));
    put( 96, enc_i(T_OP_IMM, 5'd22, 3'b101, 5'd2, 12'h01C));
    put(100, enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd23));
    put(104, enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd24));
    put(108, enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd25));
    put(112, enc_r(7'h20, 5'd1, 5'd2, 3'b101, 5'd26));
    put(116, enc_i(T_LOAD, 5'd27, 3'b001, 5'd8, 12'd4));
    put(120, enc_s(12'd12, 5'd1, 5'd8, 3'b000));
    put(124, 32'h0000_0073);
    dut.i_dmem.data_memory[67] = 32'hDEAD_BEEF;

    cycles(3);
    check("reset_pc", dut.pc, 32'h0);
    for (int i = 0; i < 32; i++) check($sformatf("reset_x%0d", i), dut.i_rf.regs[i], 32'h0);
    arst_n = 1'b1;
    cycles(1);
    check("first_edge_pc", dut.pc, 32'd4);
    check("addi_x1", dut.i_rf.regs[1], 32'd5);
    cycles(4);
    check("arith_pc", dut.pc, 32'd20);
    check("add_x3", dut.i_rf.regs[3], 32'd2);
    check("sub_x4", dut.i_rf.regs[4], 32'd8);
    check("srai_x5", dut.i_rf.regs[5], 32'hFFFF_FFFE);
    cycles(27);
    check("progA_pc", dut.pc, 32'd128);
    check("x0_zero", dut.i_rf.regs[0], 32'h0);
    check("slt_x6", dut.i_rf.regs[6], 32'd1);
    check("sltu_x7", dut.i_rf.regs[7], 32'd0);
    check("sw_mem65", dut.i_dmem.data_memory[65], 32'd5);
    check("lw_x9", dut.i_rf.regs[9], 32'd5);
    check("load_use_x12", dut.i_rf.regs[12], 32'd10);
    check("lui_x10", dut.i_rf.regs[10], 32'h1234_5000);
    check("auipc_x11", dut.i_rf.regs[11], 32'h0000_1034);
    check("sw_mem66", dut.i_dmem.data_memory[66], 32'hFFFF_FFFD);
    check("st_ld_x13", dut.i_rf.regs[13], 32'hFFFF_FFFD);
    check("xori_x14", dut.i_rf.regs[14], 32'h0000_00FA);
    check("srl_x15", dut.i_rf.regs[15], 32'h07FF_FFFF);
    check("andi_x16", dut.i_rf.regs[16], 32'h0000_00F0);
    check("ori_x17", dut.i_rf.regs[17], 32'hFFFF_FFF5);
    check("sll_x18", dut.i_rf.regs[18], 32'h0000_00A0);
    check("slti_x19", dut.i_rf.regs[19], 32'd1);
    check("sltiu_x20", dut.i_rf.regs[20], 32'd1);
    check("slli_x21", dut.i_rf.regs[21], 32'h5000_0000);
    check("srli_x22", dut.i_rf.regs[22], 32'h0000_000F);
    check("xor_x23", dut.i_rf.regs[23], 32'hFFFF_FFF8);
    check("or_x24", dut.i_rf.regs[24], 32'hFFFF_FFFD);
    check("and_x25", dut.i_rf.regs[25], 32'd5);
    check("sra_x26", dut.i_rf.regs[26], 32'hFFFF_FFFF);
    check("lh_nop_x27", dut.i_rf.regs[27], 32'h0);
    check("sb_nop_mem67", dut.i_dmem.data_memory[67], 32'hDEAD_BEEF);

    // Program B: branches and jumps
    arst_n = 1'b0;
    clear_imem();
    put(  0, enc_b(13'd8, 5'd0, 5'd0, 3'b000));
    put(  4, enc_i(T_OP_IMM, 5'd5, 3'b000, 5'd0, 12'd1));
    put(  8, enc_b(13'd24, 5'd0, 5'd1, 3'b001));
    put( 12, enc_i(T_OP_IMM, 5'd6, 3'b000, 5'd6, 12'd1));
    put( 16, enc_j(21'h1FFFF8, 5'd1));
    put( 20, enc_i(T_OP_IMM, 5'd7, 3'b000, 5'd0, 12'd9));
    put( 24, enc_j(21'd40, 5'd0));
    put( 32, enc_i(T_OP_IMM, 5'd2, 3'b000, 5'd1, 12'd1));
    put( 36, enc_i(T_JALR, 5'd3, 3'b000, 5'd2, 12'd0));
    put( 64, enc_i(T_OP_IMM, 5'd8, 3'b000, 5'd0, 12'hFFF));
    put( 68, enc_b(13'd8, 5'd0, 5'd8, 3'b100));
    put( 72, enc_i(T_OP_IMM, 5'd10, 3'b000, 5'd0, 12'd1));
    put( 76, enc_b(13'd8, 5'd0, 5'd8, 3'b110));
    put( 80, enc_i(T_OP_IMM, 5'd11, 3'b000, 5'd0, 12'd1));
    put( 84, enc_b(13'd8, 5'd8, 5'd0, 3'b101));
    put( 88, enc_i(T_OP_IMM, 5'd12, 3'b000, 5'd0, 12'd1));
    put( 92, enc_b(13'd8, 5'd8, 5'd0, 3'b111));
    put( 96, enc_i(T_OP_IMM, 5'd13, 3'b000, 5'd0, 12'd1));
    put(100, enc_b(13'd8, 5'd0, 5'd0, 3'b001));
    put(104, enc_i(T_OP_IMM, 5'd14, 3'b000, 5'd0, 12'd1));
    put(108, enc_b(13'd8, 5'd0, 5'd8, 3'b000));
    put(112, enc_i(T_OP_IMM, 5'd15, 3'b000, 5'd0, 12'd1));
    cycles(3);
    arst_n = 1'b1;
    cycles(1);
    check("beq_pc", dut.pc, 32'd8);
    cycles(3);
    check("jal_pc", dut.pc, 32'd8);
    check("jal_x1", dut.i_rf.regs[1], 32'd20);
    cycles(3);
    check("jalr_pc", dut.pc, 32'd20);
    check("jalr_x2", dut.i_rf.regs[2], 32'd21);
    check("jalr_x3", dut.i_rf.regs[3], 32'd40);
    cycles(13);
    check("progB_pc", dut.pc, 32'd116);
    check("beq_skip_x5", dut.i_rf.regs[5], 32'h0);
    check("loop_x6", dut.i_rf.regs[6], 32'd1);
    check("jalr_tgt_x7", dut.i_rf.regs[7], 32'd9);
    check("blt_skip_x10", dut.i_rf.regs[10], 32'h0);
    check("bltu_nt_x11", dut.i_rf.regs[11], 32'd1);
    check("bge_skip_x12", dut.i_rf.regs[12], 32'h0);
    check("bgeu_nt_x13", dut.i_rf.regs[13], 32'd1);
    check("bne_nt_x14", dut.i_rf.regs[14], 32'd1);
    check("beq_nt_x15", dut.i_rf.regs[15], 32'd1);

    // Program C: LUI/AUIPC at low addresses, then asynchronous reset
    arst_n = 1'b0;
    clear_imem();
    put(0, enc_u(20'h12345, 5'd10, T_LUI));
    put(4, enc_u(20'h00001, 5'd11, T_AUIPC));
    cycles(3);
    arst_n = 1'b1;
    cycles(2);
    check("lui_x10_c", dut.i_rf.regs[10], 32'h1234_5000);
    check("auipc_x11_c", dut.i_rf.regs[11], 32'h0000_1004);
    cycles(3);
    check("progC_pc", dut.pc, 32'd20);
    arst_n = 1'b0;
    #1;
    check("async_pc", dut.pc, 32'h0);
    check("async_x10", dut.i_rf.regs[10], 32'h0);
    cycles(2);
    arst_n = 1'b1;
    cycles(1);
    check("rerun_pc", dut.pc, 32'd4);
    check("rerun_x10", dut.i_rf.regs[10], 32'h1234_5000);

    // Program D: a store decoded during reset must not write memory
    arst_n = 1'b0;
    clear_imem();
    put(0, enc_s(12'h118, 5'd0, 5'd0, 3'b010));
    dut.i_dmem.data_memory[70] = 32'hCAFE_F00D;
    cycles(3);
    check("reset_no_store", dut.i_dmem.data_memory[70], 32'hCAFE_F00D);
    arst_n = 1'b1;
    cycles(1);
    check("store_after_rst", dut.i_dmem.data_memory[70], 32'h0);
    check("progD_pc", dut.pc, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
